// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared state encoding, default widths and saturation bounds for the MAC back end
package dsp_pkg;

  // Accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  // Signed bounds for the default widths
  localparam logic [DATA_W_DEF-1:0] DATA_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic [DATA_W_DEF-1:0] DATA_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};
  localparam logic [ACC_W_DEF-1:0]  ACC_MAX  = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0]  ACC_MIN  = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed clamp from IN_W bits down to OUT_W bits
module sat_clamp #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 40
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamped
);

  // The value fits when every bit from the output sign bit upward is identical
  logic [IN_W-OUT_W:0] upper;
  logic                fits;

  assign upper = din[IN_W-1:OUT_W-1];
  assign fits  = (&upper) | ~(|upper);

  // Pass through when representable, otherwise pin to the bound matching the input sign
  always_comb begin
    clamped = 1'b0;
    dout    = din[OUT_W-1:0];
    if (!fits) begin
      clamped = 1'b1;
      if (din[IN_W-1]) begin
        dout = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        dout = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/dsp_mac_accum.sv
// rtl/dsp_mac_accum.sv - saturating multiply-accumulate back end with product/result handshakes
module dsp_mac_accum
  import dsp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic [CNT_W-1:0]         len,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [DATA_W-1:0] prod,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res,
  output logic                     sat,
  output logic                     busy
);

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic                      ovf_q, ovf_d;
  logic signed [DATA_W-1:0]  res_q, res_d;
  logic                      sat_q, sat_d;

  logic signed [ACC_W:0]     sum_w;
  logic signed [ACC_W-1:0]   sum_sat;
  logic                      sum_clamped;
  logic signed [DATA_W-1:0]  res_clamp;
  logic                      res_clamped;

  // One guard bit above the accumulator so the add itself can never wrap
  assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-DATA_W){prod[DATA_W-1]}}, prod};

  sat_clamp #(
    .IN_W (ACC_W+1),
    .OUT_W(ACC_W)
  ) u_acc_clamp (
    .din    (sum_w),
    .dout   (sum_sat),
    .clamped(sum_clamped)
  );

  // Clamp the next accumulator value so the result is ready in the cycle DONE is entered
  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(DATA_W)
  ) u_res_clamp (
    .din    (acc_d),
    .dout   (res_clamp),
    .clamped(res_clamped)
  );

  assign prod_ready = (state_q == ST_ACC);
  assign res_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign res        = res_q;
  assign sat        = sat_q;

  // Next-state, accumulator and sample counter; clr overrides everything
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (len != '0) begin
              len_d   = len;
              state_d = ST_ACC;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_ACC: begin
          if (prod_valid) begin
            acc_d = sum_sat;
            ovf_d = ovf_q | sum_clamped;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture result and saturation flag only on entry to DONE so they hold through the handshake
  always_comb begin
    res_d = res_q;
    sat_d = sat_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_d = res_clamp;
      sat_d = ovf_d | res_clamped;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_accum.sv
// tb/tb_dsp_mac_accum.sv - directed self-checking bench for dsp_mac_accum
module tb_dsp_mac_accum;
  import dsp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [7:0]  len;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] prod;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic        sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dsp_mac_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .len       (len),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod      (prod),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic begin_run(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_prod(input logic [31:0] p);
    int i;
    prod       = p;
    prod_valid = 1'b1;
    i = 0;
    while (!prod_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (prod_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_prod_timeout: prod_ready=%b required 1", prod_ready);
    end
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; len = '0;
    prod_valid = 1'b0; prod = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, prod_ready, busy, sat} !== 4'b0000 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b pr=%b busy=%b sat=%b res=%h required all 0",
               res_valid, prod_ready, busy, sat, res);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    begin_run(8'd2);
    checks++;
    if (prod_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_acc_state: prod_ready=%b busy=%b required 1 1", prod_ready, busy);
    end
    send_prod(32'd2);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: res_valid=%b required 0", res_valid);
    end
    send_prod(32'd12);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'd14 || sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: rv=%b res=%h sat=%b required 1 0000000e 0", res_valid, res, sat);
    end
    take_res();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: rv=%b busy=%b required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_negative();
    begin_run(8'd2);
    send_prod(32'hFFFF_FFFB);
    send_prod(32'd3);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'hFFFF_FFFE || sat !== 1'b0) begin
      errors++;
      $display("FAIL neg_result: rv=%b res=%h sat=%b required 1 fffffffe 0", res_valid, res, sat);
    end
    take_res();
  endtask

  task automatic test_saturation();
    begin_run(8'd3);
    repeat (3) send_prod(DATA_MAX);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'h7FFF_FFFF || sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: rv=%b res=%h sat=%b required 1 7fffffff 1", res_valid, res, sat);
    end
    take_res();
    begin_run(8'd3);
    repeat (3) send_prod(DATA_MIN);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'h8000_0000 || sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: rv=%b res=%h sat=%b required 1 80000000 1", res_valid, res, sat);
    end
    take_res();
  endtask

  task automatic test_hold();
    begin_run(8'd1);
    send_prod(32'd100);
    for (int i = 0; i < 5; i++) begin
      start      = (i == 2);
      len        = 8'd4;
      prod_valid = 1'b1;
      prod       = 32'd55;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res !== 32'd100 || sat !== 1'b0 || prod_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: rv=%b res=%h sat=%b pr=%b required 1 00000064 0 0",
                 i, res_valid, res, sat, prod_ready);
      end
    end
    start = 1'b0;
    prod_valid = 1'b0;
    take_res();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rv=%b busy=%b required 0 0", res_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero_len_and_clr();
    begin_run(8'd0);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: rv=%b res=%h sat=%b required 1 00000000 0", res_valid, res, sat);
    end
    take_res();
    begin_run(8'd3);
    send_prod(32'd50);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || prod_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: busy=%b pr=%b rv=%b required 0 0 0", busy, prod_ready, res_valid);
    end
    begin_run(8'd1);
    send_prod(32'd7);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'd7 || sat !== 1'b0) begin
      errors++;
      $display("FAIL clr_next_run: rv=%b res=%h sat=%b required 1 00000007 0", res_valid, res, sat);
    end
    take_res();
  endtask

  task automatic test_async_reset();
    begin_run(8'd3);
    send_prod(32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, prod_ready, busy, sat} !== 4'b0000 || res !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rv=%b pr=%b busy=%b sat=%b res=%h required all 0",
               res_valid, prod_ready, busy, sat, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_run(8'd1);
    send_prod(32'd9);
    checks++;
    if (res_valid !== 1'b1 || res !== 32'd9 || sat !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run: rv=%b res=%h sat=%b required 1 00000009 0", res_valid, res, sat);
    end
    take_res();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_hold();
    test_zero_len_and_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
